mcb_port_responder: RTL
=======================

Name: mcb_port_responder

Overview:
- Synthesizable, BRAM-backed emulation of the MCB user port 0 (cmd / write / read FIFO interface), seen from the memory side.
- Responds to traffic_generator exactly as lpddr_memory_controller would, so UART/traffic tests run with no DRAM, PLL or calibration hardware.
- Drop-in: same port names and widths as the MCB p0 signals; single clock domain, so there are no separate cmd/wr/rd clock inputs.

Parameters:
- MEM_ADDR_WIDTH, 10: backing store depth is 2^MEM_ADDR_WIDTH 32-bit words.
- CMD_FIFO_DEPTH, 4: command FIFO entries.
- DATA_FIFO_DEPTH, 64: write and read data FIFO entries each.
- CALIB_CYCLES, 16: cycles after reset release before calib_done asserts.
- REFRESH_INTERVAL, 256: stall period; used only with the optional feature.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- calib_done  out  1  port ready.
- cmd_en  in  1  push command.
- cmd_instr  in  3  000 write, 001 read, 010 write+AP, 011 read+AP, 100 refresh.
- cmd_bl  in  6  burst length minus 1.
- cmd_byte_addr  in  30  byte address.
- cmd_empty  out  1  command FIFO empty.
- cmd_full  out  1  command FIFO full.
- wr_en  in  1  push write word.
- wr_mask  in  4  bit i = 1 means byte i is NOT written.
- wr_data  in  32  write word.
- wr_full  out  1  write FIFO full.
- wr_empty  out  1  write FIFO empty.
- wr_count  out  7  write FIFO occupancy.
- wr_underrun  out  1  write burst found the write FIFO empty.
- wr_error  out  1  sticky write-path error.
- rd_en  in  1  pop read word.
- rd_data  out  32  read FIFO head, first-word fall-through.
- rd_full  out  1  read FIFO full.
- rd_empty  out  1  read FIFO empty.
- rd_count  out  7  read FIFO occupancy.
- rd_overflow  out  1  read word dropped.
- rd_error  out  1  sticky read-path error.

Behaviour:
- Reset values: calib_done 0, cmd_empty 1, wr_empty 1, rd_empty 1, all full flags 0, counts 0, underrun/overflow/error flags 0, rd_data 0, FSM IDLE.
- Reset mid-operation clears all FIFOs and the FSM; BRAM contents are preserved.

Calibration:
- Counter runs from reset release; calib_done rises on cycle CALIB_CYCLES and stays high until reset.
- cmd_en, wr_en and rd_en are ignored while calib_done = 0.

FIFOs:
- Push and pop occur on the same rising edge; simultaneous push and pop leaves the count unchanged.
- Full and empty flags update the cycle after the edge.
- cmd_en when full: command dropped, no flag.
- wr_en when full: word dropped, wr_error set (sticky).
- rd_en when empty: ignored, no flag.
- rd_data always presents the read FIFO head; it holds its last value when the FIFO is empty.

Execution FSM (IDLE, WRITE, READ):
- IDLE: if the command FIFO is non-empty, pop one command next edge and latch:
  - word address = cmd_byte_addr[MEM_ADDR_WIDTH+1:2] (byte bits [1:0] ignored);
  - remaining = cmd_bl + 1 (1..64).
- Instruction decode:
  - 000 / 010 go to WRITE.
  - 001 / 011 go to READ.
  - 100 and undefined codes are consumed as a no-op and stay in IDLE.
- WRITE, one word per cycle:
  - Pop the write FIFO head and write the bytes whose mask bit = 0.
  - If the write FIFO is empty: write the last popped word (0 if none since reset) with mask 0000, pulse wr_underrun for 1 cycle, set wr_error.
- READ, one word per cycle:
  - BRAM read latency is 1 cycle; the word is pushed into the read FIFO the following cycle.
  - First word is visible on rd_data 3 cycles after the cmd_en edge, assuming an idle FSM and an empty command FIFO.
  - If the read FIFO is full at push: word dropped, rd_overflow pulses 1 cycle, rd_error set.
- Address wraps modulo 2^MEM_ADDR_WIDTH within a burst.
- The FSM decrements remaining each beat and returns to IDLE after the final beat; a queued command is popped on the next cycle.
- Command order is strictly FIFO. A read after a write to the same address returns the new data.

Optional Feature:
- Macro MCB_RESP_REFRESH_STALL_EN.
- Defined: a free-running counter triggers every REFRESH_INTERVAL cycles. The FSM inserts an 8-cycle stall with no BRAM access, either in IDLE or between beats; the burst resumes at the same address afterwards.
- Undefined: no stalls; a beat is issued every cycle.

Test Plan:
- Reset, then wait: calib_done = 0 for cycles 0..15 and = 1 from cycle 16; cmd_empty = 1, wr_count = 0, rd_empty = 1.
- Push 4 words 0x11111111..0x44444444, then cmd write bl = 3 addr 0x40, then cmd read bl = 3 addr 0x40 -> rd_count reaches 4; rd_data pops 0x11111111, 0x22222222, 0x33333333, 0x44444444; wr_count ends at 0.
- Write 0xAABBCCDD mask 0000 at addr 0x0, then 0x00000000 mask 1101 at 0x0; read bl = 0 -> 0xAABB00DD.
- Write cmd bl = 1 with only 1 word queued -> wr_underrun pulses once; wr_error = 1 and stays 1 until reset_n is asserted.
- Two read cmds of bl = 63 with rd_en held low -> rd_full = 1 after 64 words, rd_overflow pulses 64 times, rd_error = 1.
- 5 back-to-back cmd_en with a stalled FSM -> cmd_full = 1 after 4; the 5th is dropped. Assert reset_n mid-burst -> all FIFOs empty next cycle and BRAM data still readable afterwards.

Source files
------------

// File: rtl/mcb_port_responder.sv
// mcb_port_responder
//   BRAM-backed stand-in for MCB user port 0, seen from the memory side.
//   Commands, write words and read words pass through FIFOs just as on the
//   real controller. A small FSM executes the queued bursts against an
//   on-chip word store, so traffic tests run without DRAM, PLL or calibration.
//
// Optional feature: define MCB_RESP_REFRESH_STALL_EN to insert an 8-cycle
//   stall every REFRESH_INTERVAL cycles. A stall can fall in IDLE or between
//   beats, and no BRAM access happens during it.
//
// Ports
//   clk, reset_n              sole clock, asynchronous active-low reset
//   calib_done                port ready (CALIB_CYCLES after reset release)
//   cmd_en/instr/bl/byte_addr command push; cmd_empty/cmd_full status
//   wr_en/mask/data           write-word push; wr_full/empty/count status
//   wr_underrun, wr_error     burst found no write data / sticky write error
//   rd_en, rd_data            read pop, first-word fall-through head
//   rd_full/empty/count       read FIFO status
//   rd_overflow, rd_error     read word dropped / sticky read error

// Synchronous FIFO with a registered fall-through head. The head register
// holds its last value once the FIFO drains.
module mcb_resp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             full_reg, empty_reg;
  logic             push_ok, pop_ok;
  logic [WIDTH-1:0] head_reg;

  assign push_ok     = push && !full_reg;
  assign pop_ok      = pop && !empty_reg;
  assign count_next  = count_reg + CW'(push_ok) - CW'(pop_ok);
  assign rd_ptr_next = rd_ptr_reg + PW'(pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      head_reg   <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      full_reg   <= (count_next == CW'(DEPTH));
      empty_reg  <= (count_next == '0);
      // The pushed word becomes the head when nothing older survives the pop;
      // the array slot is not written yet, so bypass it.
      if (push_ok && (count_reg == CW'(pop_ok)))
        head_reg <= push_data;
      else if (count_next != '0)
        head_reg <= mem[rd_ptr_next];
    end
  end

  assign head  = head_reg;
  assign count = count_reg;
  assign full  = full_reg;
  assign empty = empty_reg;
endmodule

module mcb_port_responder #(
  parameter int MEM_ADDR_WIDTH   = 10,
  parameter int CMD_FIFO_DEPTH   = 4,
  parameter int DATA_FIFO_DEPTH  = 64,
  parameter int CALIB_CYCLES     = 16,
  parameter int REFRESH_INTERVAL = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        calib_done,
  input  logic        cmd_en,
  input  logic [2:0]  cmd_instr,
  input  logic [5:0]  cmd_bl,
  input  logic [29:0] cmd_byte_addr,
  output logic        cmd_empty,
  output logic        cmd_full,
  input  logic        wr_en,
  input  logic [3:0]  wr_mask,
  input  logic [31:0] wr_data,
  output logic        wr_full,
  output logic        wr_empty,
  output logic [6:0]  wr_count,
  output logic        wr_underrun,
  output logic        wr_error,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        rd_full,
  output logic        rd_empty,
  output logic [6:0]  rd_count,
  output logic        rd_overflow,
  output logic        rd_error
);
  localparam int AW        = MEM_ADDR_WIDTH;
  localparam int MEM_WORDS = 1 << AW;
  localparam int CMDW      = 3 + 6 + AW;
  localparam int CALW      = $clog2(CALIB_CYCLES + 1);
  localparam logic [AW-1:0] ADDR_ONE = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

  // ---------------- calibration ----------------
  logic [CALW-1:0] cal_cnt_reg;
  logic            calib_done_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cal_cnt_reg    <= '0;
      calib_done_reg <= 1'b0;
    end else if (!calib_done_reg) begin
      cal_cnt_reg <= cal_cnt_reg + CALW'(1);
      if (cal_cnt_reg == CALW'(CALIB_CYCLES - 1)) calib_done_reg <= 1'b1;
    end
  end
  assign calib_done = calib_done_reg;

  // ---------------- stall source ----------------
  logic stall;
`ifdef MCB_RESP_REFRESH_STALL_EN
  localparam int RW = $clog2(REFRESH_INTERVAL);
  logic [RW-1:0] refresh_cnt_reg;
  logic [3:0]    stall_cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh_cnt_reg <= '0;
      stall_cnt_reg   <= '0;
    end else if (refresh_cnt_reg == RW'(REFRESH_INTERVAL - 1)) begin
      refresh_cnt_reg <= '0;
      stall_cnt_reg   <= 4'd8;
    end else begin
      refresh_cnt_reg <= refresh_cnt_reg + RW'(1);
      if (stall_cnt_reg != 4'd0) stall_cnt_reg <= stall_cnt_reg - 4'd1;
    end
  end
  assign stall = (stall_cnt_reg != 4'd0);
`else
  logic [31:0] unused_refresh;
  assign unused_refresh = REFRESH_INTERVAL;
  assign stall = 1'b0;
`endif

  // ---------------- FIFOs ----------------
  logic [CMDW-1:0]                cmd_head;
  logic [$clog2(CMD_FIFO_DEPTH):0] cmd_count;
  logic                           cmd_pop;
  logic [35:0]                    wr_head;
  logic                           wr_pop;
  logic [31:0]                    mem_rdata;
  logic                           rd_valid_reg;

  // Only the word-address bits are kept; byte offset and high bits are unused.
  mcb_resp_fifo #(.WIDTH(CMDW), .DEPTH(CMD_FIFO_DEPTH)) u_cmd_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (cmd_en && calib_done_reg),
    .push_data ({cmd_instr, cmd_bl, cmd_byte_addr[AW+1:2]}),
    .pop       (cmd_pop),
    .head      (cmd_head),
    .count     (cmd_count),
    .full      (cmd_full),
    .empty     (cmd_empty)
  );

  mcb_resp_fifo #(.WIDTH(36), .DEPTH(DATA_FIFO_DEPTH)) u_wr_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (wr_en && calib_done_reg),
    .push_data ({wr_mask, wr_data}),
    .pop       (wr_pop),
    .head      (wr_head),
    .count     (wr_count),
    .full      (wr_full),
    .empty     (wr_empty)
  );

  mcb_resp_fifo #(.WIDTH(32), .DEPTH(DATA_FIFO_DEPTH)) u_rd_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rd_valid_reg),
    .push_data (mem_rdata),
    .pop       (rd_en && calib_done_reg),
    .head      (rd_data),
    .count     (rd_count),
    .full      (rd_full),
    .empty     (rd_empty)
  );

  logic unused_bits;
  assign unused_bits = ^{cmd_count, cmd_byte_addr[29:AW+2], cmd_byte_addr[1:0]};

  // ---------------- execution FSM ----------------
  state_t        state_reg, state_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [6:0]    remain_reg, remain_next;
  logic [31:0]   last_word_reg, last_word_next;
  logic [3:0]    mem_we;
  logic [31:0]   mem_wdata;
  logic          mem_re;
  logic          underrun_next;

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remain_next    = remain_reg;
    last_word_next = last_word_reg;
    cmd_pop        = 1'b0;
    wr_pop         = 1'b0;
    mem_we         = 4'h0;
    mem_wdata      = last_word_reg;
    mem_re         = 1'b0;
    underrun_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!cmd_empty && !stall) begin
          cmd_pop     = 1'b1;
          addr_next   = cmd_head[AW-1:0];
          remain_next = {1'b0, cmd_head[AW +: 6]} + 7'd1;
          case (cmd_head[CMDW-1 -: 3])
            3'b000, 3'b010: state_next = ST_WRITE;
            3'b001, 3'b011: state_next = ST_READ;
            default:        state_next = ST_IDLE;  // refresh / undefined: no-op
          endcase
        end
      end
      ST_WRITE: begin
        if (!stall) begin
          if (!wr_empty) begin
            wr_pop         = 1'b1;
            mem_we         = ~wr_head[35:32];
            mem_wdata      = wr_head[31:0];
            last_word_next = wr_head[31:0];
          end else begin
            // Starved beat: repeat the previous word with every byte enabled.
            mem_we        = 4'hF;
            underrun_next = 1'b1;
          end
          addr_next   = addr_reg + ADDR_ONE;
          remain_next = remain_reg - 7'd1;
          if (remain_reg == 7'd1) state_next = ST_IDLE;
        end
      end
      ST_READ: begin
        if (!stall) begin
          mem_re      = 1'b1;
          addr_next   = addr_reg + ADDR_ONE;
          remain_next = remain_reg - 7'd1;
          if (remain_reg == 7'd1) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_IDLE;
      addr_reg        <= '0;
      remain_reg      <= '0;
      last_word_reg   <= '0;
      rd_valid_reg    <= 1'b0;
      wr_underrun     <= 1'b0;
      rd_overflow     <= 1'b0;
      wr_error        <= 1'b0;
      rd_error        <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remain_reg    <= remain_next;
      last_word_reg <= last_word_next;
      rd_valid_reg  <= mem_re;
      wr_underrun   <= underrun_next;
      rd_overflow   <= rd_valid_reg && rd_full;
      if (underrun_next || (wr_en && calib_done_reg && wr_full)) wr_error <= 1'b1;
      if (rd_valid_reg && rd_full) rd_error <= 1'b1;
    end
  end

  // ---------------- backing store: one byte lane per array ----------------
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane [0:MEM_WORDS-1];
      logic [7:0] lane_q_reg;
      always_ff @(posedge clk) begin
        if (mem_we[gi]) lane[addr_reg] <= mem_wdata[gi*8 +: 8];
        if (mem_re)     lane_q_reg     <= lane[addr_reg];
      end
      assign mem_rdata[gi*8 +: 8] = lane_q_reg;
    end
  endgenerate
endmodule
